// File: rtl/ifetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input and decode-side entry.
// No latency of its own; it only groups the wires.
// Backpressure flows decode -> fetch on if_ready; memory is same-cycle, so it has no stall.
interface ifetch_ctrl_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_exc_en;
  logic [3:0]  if_exc_code;
  logic [63:0] if_exc_val;

  // Fetch controller side.
  modport master (
    output imem_addr,
    input  imem_instr,
    input  imem_exc_en,
    input  imem_exc_code,
    input  imem_exc_val,
    input  redirect_en,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output if_exc_en,
    output if_exc_code,
    output if_exc_val
  );

  // Memory, redirect source and decode side.
  modport slave (
    input  imem_addr,
    output imem_instr,
    output imem_exc_en,
    output imem_exc_code,
    output imem_exc_val,
    output redirect_en,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  if_exc_en,
    input  if_exc_code,
    input  if_exc_val
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: pc register, one-entry output register, FETCH/FAULT FSM.
// Latency: the word at imem_addr=A appears on if_* one cycle later; one entry per cycle.
// Backpressure: if_valid && !if_ready stalls pc and entry; a redirect flushes the entry.
module ifetch_ctrl #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_ctrl_if.master bus
);

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
  } entry_t;

  logic [63:0] r_pc;
  logic [0:0]  r_state;
  logic        r_if_valid;
  entry_t      r_entry;

  logic        w_slot_free;
  logic        w_capture;
  logic        w_misaligned;
  logic        w_fault;
  entry_t      w_cap_entry;

  // The slot frees up when it is empty or its entry is taken at this edge.
  assign w_slot_free  = !r_if_valid || bus.if_ready;
  // A redirect cycle never captures; the fetch at the old pc is discarded.
  assign w_capture    = !bus.redirect_en && (r_state == ST_FETCH) && w_slot_free;
  assign w_misaligned = (r_pc[1:0] != 2'b00);
  assign w_fault      = w_misaligned || bus.imem_exc_en;

  // Build the entry for the current fetch; misalignment outranks a memory fault.
  always_comb begin
    w_cap_entry = '{instr: bus.imem_instr, pc: r_pc, exc_en: 1'b0,
                    exc_code: 4'd0, exc_val: 64'd0};
    if (w_misaligned) begin
      w_cap_entry.instr    = NOP_INSTR;
      w_cap_entry.exc_en   = 1'b1;
      w_cap_entry.exc_code = 4'd0;
      w_cap_entry.exc_val  = r_pc;
    end else if (bus.imem_exc_en) begin
      w_cap_entry.instr    = NOP_INSTR;
      w_cap_entry.exc_en   = 1'b1;
      w_cap_entry.exc_code = bus.imem_exc_code;
      w_cap_entry.exc_val  = bus.imem_exc_val;
    end
  end

  // pc, state and output entry: reset, then redirect, then capture/stall/fault drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_state    <= ST_FETCH;
      r_if_valid <= 1'b0;
      r_entry    <= '{instr: NOP_INSTR, pc: 64'd0, exc_en: 1'b0,
                      exc_code: 4'd0, exc_val: 64'd0};
    end else if (bus.redirect_en) begin
      r_pc       <= bus.redirect_pc;
      r_state    <= ST_FETCH;
      r_if_valid <= 1'b0;
    end else if (w_capture) begin
      r_if_valid <= 1'b1;
      r_entry    <= w_cap_entry;
      if (w_fault) begin
        // pc parks on the faulting address until someone redirects us.
        r_state <= ST_FAULT;
      end else begin
        r_pc <= r_pc + 64'd4;
      end
    end else if ((r_state == ST_FAULT) && r_if_valid && bus.if_ready) begin
      // Fault entry consumed; stay idle so exactly one is issued.
      r_if_valid <= 1'b0;
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.if_valid    = r_if_valid;
  assign bus.if_instr    = r_entry.instr;
  assign bus.if_pc       = r_entry.pc;
  assign bus.if_exc_en   = r_entry.exc_en;
  assign bus.if_exc_code = r_entry.exc_code;
  assign bus.if_exc_val  = r_entry.exc_val;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Testbench for ifetch_ctrl: directed scenarios plus randomized stream vs a stream model.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Decode backpressure and redirects are randomized in the stream test.
module tb_ifetch_ctrl;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [31:0] NOP      = 32'h00000013;

  typedef struct packed {
    logic        vld;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        exc;
    logic [3:0]  code;
    logic [63:0] val;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_ctrl_if u_bus ();

  ifetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory fault injection: 0 = none, 1 = single address, 2 = one word per 128 bytes.
  int          fault_mode = 0;
  logic [63:0] fault_addr = 64'd0;
  logic [3:0]  fault_code = 4'd0;
  logic [63:0] fault_val  = 64'd0;
  logic [63:0] w_addr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'd0:   return 32'h00000011;
      64'd4:   return 32'h00000022;
      64'd8:   return 32'h00000033;
      default: return {a[47:40] ^ 8'h5A, 8'hC3, a[15:0]};
    endcase
  endfunction

  assign w_addr              = u_bus.imem_addr;
  assign u_bus.imem_instr    = mem_word(w_addr);
  assign u_bus.imem_exc_en   = ((fault_mode == 1) && (w_addr == fault_addr)) ||
                               ((fault_mode == 2) && (w_addr[6:2] == 5'd13));
  assign u_bus.imem_exc_code = (fault_mode == 1) ? fault_code : w_addr[11:8];
  assign u_bus.imem_exc_val  = (fault_mode == 1) ? fault_val  : (w_addr ^ 64'hF00);

  // What decode should receive for the entry fetched at address a.
  function automatic ent_t expect_entry(input logic [63:0] a);
    ent_t e;
    logic mexc;
    mexc = ((fault_mode == 1) && (a == fault_addr)) ||
           ((fault_mode == 2) && (a[6:2] == 5'd13));
    if (a[1:0] != 2'b00)
      e = '{vld: 1'b1, instr: NOP, pc: a, exc: 1'b1, code: 4'd0, val: a};
    else if (mexc)
      e = '{vld: 1'b1, instr: NOP, pc: a, exc: 1'b1,
            code: (fault_mode == 1) ? fault_code : a[11:8],
            val:  (fault_mode == 1) ? fault_val  : (a ^ 64'hF00)};
    else
      e = '{vld: 1'b1, instr: mem_word(a), pc: a, exc: 1'b0, code: 4'd0, val: 64'd0};
    return e;
  endfunction

  function automatic ent_t observed();
    ent_t o;
    o = '{vld: u_bus.if_valid, instr: u_bus.if_instr, pc: u_bus.if_pc,
          exc: u_bus.if_exc_en, code: u_bus.if_exc_code, val: u_bus.if_exc_val};
    return o;
  endfunction

  localparam ent_t RESET_ENT = '{vld: 1'b0, instr: NOP, pc: 64'd0, exc: 1'b0,
                                 code: 4'd0, val: 64'd0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_release(input logic ready);
    rst = 1'b1;
    u_bus.redirect_en = 1'b0;
    u_bus.if_ready = ready;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ent_t o;
    rst = 1'b1;
    u_bus.redirect_en = 1'b1;
    u_bus.redirect_pc = 64'h500;
    u_bus.if_ready = 1'b0;
    fault_mode = 0;
    tick();
    tick();
    o = observed();
    checks++;
    if (o !== RESET_ENT) begin
      errors++;
      $display("FAIL reset_entry: got %h expected %h", o, RESET_ENT);
    end
    checks++;
    if (u_bus.imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_addr: got %h expected %h", u_bus.imem_addr, RESET_PC);
    end
    u_bus.redirect_en = 1'b0;
  endtask

  task automatic test_stream();
    ent_t o, e;
    logic [31:0] words [3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    reset_release(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      o = observed();
      e = '{vld: 1'b1, instr: words[i], pc: 64'(4 * i), exc: 1'b0, code: 4'd0, val: 64'd0};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stream_%0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_backpressure();
    reset_release(1'b1);
    tick();
    tick();
    u_bus.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({u_bus.if_valid, u_bus.if_pc, u_bus.if_instr, u_bus.imem_addr} !==
          {1'b1, 64'd4, 32'h22, 64'd8}) begin
        errors++;
        $display("FAIL stall_%0d: got v=%b pc=%h instr=%h addr=%h expected v=1 pc=4 instr=22 addr=8",
                 i, u_bus.if_valid, u_bus.if_pc, u_bus.if_instr, u_bus.imem_addr);
      end
    end
    u_bus.if_ready = 1'b1;
    tick();
    checks++;
    if ({u_bus.if_valid, u_bus.if_pc, u_bus.if_instr} !== {1'b1, 64'd8, 32'h33}) begin
      errors++;
      $display("FAIL stall_release: got v=%b pc=%h instr=%h expected v=1 pc=8 instr=33",
               u_bus.if_valid, u_bus.if_pc, u_bus.if_instr);
    end
  endtask

  task automatic test_redirect_stall();
    ent_t o, e;
    reset_release(1'b1);
    tick();
    u_bus.if_ready = 1'b0;
    tick();
    u_bus.redirect_en = 1'b1;
    u_bus.redirect_pc = 64'h100;
    tick();
    u_bus.redirect_en = 1'b0;
    checks++;
    if ({u_bus.if_valid, u_bus.imem_addr} !== {1'b0, 64'h100}) begin
      errors++;
      $display("FAIL redirect_flush: got v=%b addr=%h expected v=0 addr=100",
               u_bus.if_valid, u_bus.imem_addr);
    end
    u_bus.if_ready = 1'b1;
    tick();
    o = observed();
    e = '{vld: 1'b1, instr: mem_word(64'h100), pc: 64'h100, exc: 1'b0, code: 4'd0, val: 64'd0};
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL redirect_target: got %h expected %h", o, e);
    end
  endtask

  task automatic test_access_fault();
    ent_t o, e;
    fault_mode = 1;
    fault_addr = 64'h2000;
    fault_code = 4'd1;
    fault_val  = 64'h2000;
    u_bus.if_ready = 1'b1;
    u_bus.redirect_en = 1'b1;
    u_bus.redirect_pc = 64'h2000;
    tick();
    u_bus.redirect_en = 1'b0;
    tick();
    o = observed();
    e = '{vld: 1'b1, instr: NOP, pc: 64'h2000, exc: 1'b1, code: 4'd1, val: 64'h2000};
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL access_fault_entry: got %h expected %h", o, e);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({u_bus.if_valid, u_bus.imem_addr} !== {1'b0, 64'h2000}) begin
        errors++;
        $display("FAIL fault_idle_%0d: got v=%b addr=%h expected v=0 addr=2000",
                 i, u_bus.if_valid, u_bus.imem_addr);
      end
    end
    u_bus.redirect_en = 1'b1;
    u_bus.redirect_pc = 64'h40;
    tick();
    u_bus.redirect_en = 1'b0;
    tick();
    o = observed();
    e = '{vld: 1'b1, instr: mem_word(64'h40), pc: 64'h40, exc: 1'b0, code: 4'd0, val: 64'd0};
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL fault_resume: got %h expected %h", o, e);
    end
    fault_mode = 0;
  endtask

  task automatic test_misalign();
    ent_t o, e;
    fault_mode = 1;
    fault_addr = 64'h102;
    fault_code = 4'h7;
    fault_val  = 64'hBEEF;
    u_bus.if_ready = 1'b0;
    u_bus.redirect_en = 1'b1;
    u_bus.redirect_pc = 64'h102;
    tick();
    u_bus.redirect_en = 1'b0;
    tick();
    o = observed();
    e = '{vld: 1'b1, instr: NOP, pc: 64'h102, exc: 1'b1, code: 4'd0, val: 64'h102};
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL misalign_entry: got %h expected %h", o, e);
    end
    checks++;
    if (u_bus.imem_addr !== 64'h102) begin
      errors++;
      $display("FAIL misalign_pc_hold: got %h expected 102", u_bus.imem_addr);
    end
    u_bus.if_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (u_bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_single: got v=%b expected 0", u_bus.if_valid);
    end
    fault_mode = 0;
  endtask

  task automatic test_reset_mid_fault();
    ent_t o, e;
    u_bus.if_ready = 1'b0;
    u_bus.redirect_en = 1'b1;
    u_bus.redirect_pc = 64'h6;
    tick();
    u_bus.redirect_en = 1'b0;
    tick();
    tick();
    checks++;
    if ({u_bus.if_valid, u_bus.if_exc_en} !== 2'b11) begin
      errors++;
      $display("FAIL midfault_setup: got v=%b exc=%b expected 1 1", u_bus.if_valid, u_bus.if_exc_en);
    end
    rst = 1'b1;
    u_bus.redirect_en = 1'b1;
    u_bus.redirect_pc = 64'h300;
    tick();
    o = observed();
    checks++;
    if (o !== RESET_ENT) begin
      errors++;
      $display("FAIL midfault_reset_entry: got %h expected %h", o, RESET_ENT);
    end
    checks++;
    if (u_bus.imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL midfault_reset_addr: got %h expected %h", u_bus.imem_addr, RESET_PC);
    end
    rst = 1'b0;
    u_bus.redirect_en = 1'b0;
    u_bus.if_ready = 1'b1;
    tick();
    o = observed();
    e = '{vld: 1'b1, instr: mem_word(RESET_PC), pc: RESET_PC, exc: 1'b0, code: 4'd0, val: 64'd0};
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL first_capture: got %h expected %h", o, e);
    end
  endtask

  task automatic test_wrap();
    ent_t o, e;
    logic [63:0] a;
    u_bus.if_ready = 1'b1;
    u_bus.redirect_en = 1'b1;
    u_bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    u_bus.redirect_en = 1'b0;
    a = 64'hFFFF_FFFF_FFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      tick();
      o = observed();
      e = '{vld: 1'b1, instr: mem_word(a), pc: a, exc: 1'b0, code: 4'd0, val: 64'd0};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_%0d: got %h expected %h", i, o, e);
      end
      a = a + 64'd4;
    end
  endtask

  // Model: accepted entries form a consecutive address stream from the last reset or
  // redirect target, ending after the first fault entry; flushed entries never count.
  task automatic test_random();
    ent_t o, e, prev_o;
    logic [63:0] exp_pc, rpc;
    logic faulted, prev_redirect, prev_stall, rdy, redir;
    fault_mode = 2;
    reset_release(1'b1);
    exp_pc = RESET_PC;
    faulted = 1'b0;
    prev_redirect = 1'b0;
    prev_stall = 1'b0;
    prev_o = RESET_ENT;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      o = observed();
      if (prev_stall) begin
        checks++;
        if (o !== prev_o) begin
          errors++;
          $display("FAIL rnd_stable cyc=%0d: got %h expected %h", cyc, o, prev_o);
        end
      end
      checks++;
      if (o.vld !== (!prev_redirect && !faulted)) begin
        errors++;
        $display("FAIL rnd_valid cyc=%0d: got %b expected %b", cyc, o.vld, !prev_redirect && !faulted);
      end
      if (o.vld && !o.exc) begin
        checks++;
        if (u_bus.imem_addr !== o.pc + 64'd4) begin
          errors++;
          $display("FAIL rnd_addr cyc=%0d: got %h expected %h", cyc, u_bus.imem_addr, o.pc + 64'd4);
        end
      end
      rdy = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 99) < 5);
      case ($urandom_range(0, 3))
        0: rpc = 64'($urandom_range(0, 1023)) << 2;
        1: rpc = (64'($urandom_range(0, 1023)) << 2) + 64'($urandom_range(0, 3));
        2: rpc = 64'hFFFF_FFFF_FFFF_FFF0 + (64'($urandom_range(0, 3)) << 2);
        default: rpc = {32'($urandom), 32'($urandom)} & ~64'd3;
      endcase
      u_bus.if_ready = rdy;
      u_bus.redirect_en = redir;
      u_bus.redirect_pc = rpc;
      if (redir) begin
        exp_pc = rpc;
        faulted = 1'b0;
        prev_redirect = 1'b1;
        prev_stall = 1'b0;
      end else begin
        prev_redirect = 1'b0;
        prev_stall = o.vld && !rdy;
        prev_o = o;
        if (o.vld && rdy) begin
          e = expect_entry(exp_pc);
          checks++;
          if (o !== e) begin
            errors++;
            $display("FAIL rnd_entry cyc=%0d: got %h expected %h", cyc, o, e);
          end
          if (e.exc) faulted = 1'b1;
          else exp_pc = exp_pc + 64'd4;
        end
      end
    end
    u_bus.redirect_en = 1'b0;
    fault_mode = 0;
  endtask

  initial begin
    rst = 1'b1;
    u_bus.if_ready = 1'b0;
    u_bus.redirect_en = 1'b0;
    u_bus.redirect_pc = 64'd0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stall();
    test_access_fault();
    test_misalign();
    test_reset_mid_fault();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
